// File: rtl/transfer_center.sv
// Serial-to-parallel transfer center: receives a framed serial word and offers it to one of two local scanners in turn.
// Optional even-parity check on the frame is enabled by defining TRANSFER_CENTER_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for readyForTransferIn; outputs cleared
// RECEIVE | shifting frame bits in, MSB first
// HOLD    | completed word offered on dataBuffer for HOLD_CYCLES cycles
module transfer_center #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dataIn,
    input  logic                  readyForTransferIn,
    output logic                  readyForTransferOut,
    output logic [1:0]            localScannerOut,
    output logic [DATA_WIDTH-1:0] dataBuffer
);

`ifdef TRANSFER_CENTER_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif

    // Counter covers DATA_WIDTH+1 so the parity frame never wraps it
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bitCount;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [3:0]            holdCount;
    logic                  destSel;

    logic [DATA_WIDTH-1:0] shiftNext;
    logic [DATA_WIDTH-1:0] frameWord;
    logic                  frameGood;
    logic                  lastBit;

    assign shiftNext = DATA_WIDTH'({shiftReg, dataIn});
    assign lastBit   = (bitCount == LAST_BIT);

`ifdef TRANSFER_CENTER_PARITY_EN
    // On the parity edge the data bits are already complete in shiftReg
    assign frameWord = shiftReg;
    assign frameGood = ~((^shiftReg) ^ dataIn);
`else
    assign frameWord = shiftNext;
    assign frameGood = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            bitCount            <= '0;
            shiftReg            <= '0;
            holdCount           <= '0;
            destSel             <= 1'b0;
            dataBuffer          <= '0;
            readyForTransferOut <= 1'b0;
            localScannerOut     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    readyForTransferOut <= 1'b0;
                    localScannerOut     <= 2'b00;
                    if (readyForTransferIn) begin
                        state    <= RECEIVE;
                        bitCount <= '0;
                    end
                end
                RECEIVE: begin
                    shiftReg <= shiftNext;
                    bitCount <= bitCount + 1'b1;
                    if (lastBit) begin
                        if (frameGood) begin
                            state               <= HOLD;
                            holdCount           <= HOLD_LOAD;
                            dataBuffer          <= frameWord;
                            readyForTransferOut <= 1'b1;
                            localScannerOut     <= destSel ? 2'b10 : 2'b01;
                            destSel             <= ~destSel;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (holdCount == 4'd0) begin
                        state               <= IDLE;
                        readyForTransferOut <= 1'b0;
                        localScannerOut     <= 2'b00;
                    end else begin
                        holdCount <= holdCount - 1'b1;
                    end
                end
                default: begin
                    state               <= IDLE;
                    readyForTransferOut <= 1'b0;
                    localScannerOut     <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transfer_center.sv
// Self-checking bench for transfer_center: directed frames plus randomized traffic against a frame-timing model.
// Build with TRANSFER_CENTER_PARITY_EN defined to exercise the parity variant.
module tb_transfer_center;

    localparam int DW = 8;
    localparam int HC = 4;
`ifdef TRANSFER_CENTER_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = DW + 1;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dataIn;
    logic          readyForTransferIn;
    logic          readyForTransferOut;
    logic [1:0]    localScannerOut;
    logic [DW-1:0] dataBuffer;

    transfer_center #(.DATA_WIDTH(DW), .HOLD_CYCLES(HC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dataIn              (dataIn),
        .readyForTransferIn  (readyForTransferIn),
        .readyForTransferOut (readyForTransferOut),
        .localScannerOut     (localScannerOut),
        .dataBuffer          (dataBuffer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int k      = 0;

    // Frame-timing model: a frame started at edge s delivers at edge s+NB,
    // stays offered for HC edges, and the next start is accepted at s+NB+HC+1.
    bit            frameActive;
    int            frameStart;
    int            nextStart;
    int            readyUntil;
    int            delivered;
    logic [DW-1:0] mWord;
    logic          mPar;
    logic [DW-1:0] expBuf;
    logic [1:0]    curDest;
    logic          expReady;
    logic [1:0]    expScan;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
        end
    endtask

    task automatic modelReset();
        frameActive = 1'b0;
        nextStart   = 0;
        readyUntil  = 0;
        delivered   = 0;
        expBuf      = '0;
        curDest     = 2'b01;
        expReady    = 1'b0;
        expScan     = 2'b00;
        mWord       = '0;
        mPar        = 1'b0;
    endtask

    task automatic modelStep(input logic rdy, input logic din);
        int idx;
        if (frameActive) begin
            idx = k - frameStart;
            if (idx <= DW) mWord = {mWord[DW-2:0], din};
            else           mPar  = din;
            if (idx == NB) begin
                frameActive = 1'b0;
                if (PAR && (($countones(mWord) + int'(mPar)) % 2 != 0)) begin
                    nextStart = k + 1;
                end else begin
                    expBuf     = mWord;
                    curDest    = (delivered % 2 == 0) ? 2'b01 : 2'b10;
                    delivered++;
                    readyUntil = k + HC;
                    nextStart  = k + HC + 1;
                end
            end
        end else if (rdy && k >= nextStart) begin
            frameActive = 1'b1;
            frameStart  = k;
            mWord       = '0;
        end
        expReady = (k < readyUntil);
        expScan  = expReady ? curDest : 2'b00;
    endtask

    task automatic cycle(input logic rdy, input logic din);
        readyForTransferIn = rdy;
        dataIn             = din;
        @(posedge clk);
        k++;
        if (rst) modelStep(rdy, din);
        #1;
    endtask

    task automatic asyncReset();
        rst = 1'b0;
        #1;
        modelReset();
        chk("rst_buf",   32'(dataBuffer),          32'h0);
        chk("rst_ready", 32'(readyForTransferOut), 32'h0);
        chk("rst_scan",  32'(localScannerOut),     32'h0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        rst = 1'b1;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (frameActive || k + 1 < nextStart) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            guard++;
            if (guard > 100) begin
                checks++;
                fails++;
                $display("FAIL wait_idle: still busy after %0d cycles", guard);
                break;
            end
        end
    endtask

    task automatic sendFrame(input logic [DW-1:0] word, input logic parBit, input bit toggleRdy);
        waitIdle();
        cycle(1'b1, 1'($urandom_range(0, 1)));
        for (int i = DW - 1; i >= 0; i--)
            cycle(toggleRdy ? 1'(i % 2) : 1'b0, word[i]);
        if (PAR) cycle(toggleRdy, parBit);
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(readyForTransferOut), 32'(expReady));
        chk("scan",  32'(localScannerOut),     32'(expScan));
        chk("buf",   32'(dataBuffer),          32'(expBuf));
    end

    initial begin
        rst                = 1'b0;
        readyForTransferIn = 1'b0;
        dataIn             = 1'b0;
        modelReset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst = 1'b1;
        chk("init_buf",   32'(dataBuffer),          32'h0);
        chk("init_ready", 32'(readyForTransferOut), 32'h0);
        chk("init_scan",  32'(localScannerOut),     32'h0);

        sendFrame(8'hA5, 1'b0, 1'b0);
        chk("a5_buf",   32'(dataBuffer),          32'hA5);
        chk("a5_ready", 32'(readyForTransferOut), 32'h1);
        chk("a5_scan",  32'(localScannerOut),     32'h1);
        repeat (3) cycle(1'b0, 1'b0);
        chk("a5_hold_last", 32'(readyForTransferOut), 32'h1);
        cycle(1'b0, 1'b0);
        chk("a5_hold_end",  32'(readyForTransferOut), 32'h0);
        chk("a5_scan_end",  32'(localScannerOut),     32'h0);
        chk("a5_buf_kept",  32'(dataBuffer),          32'hA5);

        sendFrame(8'hFF, 1'b0, 1'b0);
        chk("ff_buf",  32'(dataBuffer),      32'hFF);
        chk("ff_scan", 32'(localScannerOut), 32'h2);
        sendFrame(8'h3C, 1'b0, 1'b0);
        chk("third_scan", 32'(localScannerOut), 32'h1);

        waitIdle();
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        asyncReset();
        sendFrame(8'h3C, 1'b0, 1'b0);
        chk("post_rst_buf",  32'(dataBuffer),      32'h3C);
        chk("post_rst_scan", 32'(localScannerOut), 32'h1);

        sendFrame(8'h81, 1'b0, 1'b1);
        chk("toggle_buf",  32'(dataBuffer),      32'h81);
        chk("toggle_scan", 32'(localScannerOut), 32'h2);
        repeat (HC + 6) cycle(1'b0, 1'b0);
        chk("toggle_single", 32'(readyForTransferOut), 32'h0);

`ifdef TRANSFER_CENTER_PARITY_EN
        sendFrame(8'hA5, 1'b1, 1'b0);
        chk("par_bad_ready", 32'(readyForTransferOut), 32'h0);
        chk("par_bad_buf",   32'(dataBuffer),          32'h81);
        sendFrame(8'h0F, 1'b0, 1'b0);
        chk("par_next_buf",  32'(dataBuffer),      32'h0F);
        chk("par_next_scan", 32'(localScannerOut), 32'h1);
`endif

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) asyncReset();
            else cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/transfer_center.md
TRANSFER_CENTER -- requirements
Module: transfer_center

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the received word and of dataBuffer.
REQ-002 Parameter HOLD_CYCLES, default 4, cycles a completed word is offered to a local scanner (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dataIn  input  1  serial data bit, MSB first.
REQ-006 readyForTransferIn  input  1  remote sender requests a transfer; sampled only in IDLE.
REQ-007 readyForTransferOut  output  1  high while a completed word is offered on dataBuffer.
REQ-008 localScannerOut  output  2  one-hot destination scanner select: 01 = scanner 0, 10 = scanner 1, 00 = none.
REQ-009 dataBuffer  output  DATA_WIDTH  last completed word.

Function
REQ-010 The FSM SHALL have the states IDLE, RECEIVE and HOLD; all outputs are registered.
REQ-011 IDLE: readyForTransferOut=0, localScannerOut=00; readyForTransferIn=1 at an edge -> RECEIVE, bit counter cleared; dataIn at that edge is not sampled.
REQ-012 RECEIVE: each edge shifts dataIn into bit 0 of an internal shift register (shift left) and increments the counter; dataBuffer stays unchanged during reception.
REQ-013 readyForTransferIn SHALL be ignored in RECEIVE and HOLD; a transfer, once started, always runs to completion.
REQ-014 On the edge sampling the last frame bit (DATA_WIDTH bits, or DATA_WIDTH+1 with parity), the FSM SHALL go to HOLD.
REQ-015 On that same edge, dataBuffer SHALL take the assembled word, readyForTransferOut SHALL go to 1, and localScannerOut SHALL take the current destination.
REQ-016 Latency: outputs valid in the cycle after the last bit is sampled; a frame with N bits takes N+1 cycles from readyForTransferIn sampled high to readyForTransferOut high.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to IDLE.
REQ-018 On leaving HOLD: readyForTransferOut=0, localScannerOut=00, dataBuffer retained.
REQ-019 Destination pointer SHALL start at scanner 0 and toggle after each delivered word (01, 10, 01, ...).
REQ-020 If readyForTransferIn is high on the edge that enters IDLE from HOLD, it is honoured on the next edge; minimum gap between frames is one IDLE cycle.
REQ-021 An internal counter SHALL be wide enough for DATA_WIDTH+1 and SHALL never wrap within a frame.

Reset
REQ-022 rst=0 SHALL immediately, without a clock, force state IDLE, counter 0, shift register 0, dataBuffer 0, readyForTransferOut 0, localScannerOut 00, and destination pointer to scanner 0.
REQ-023 Reset asserted mid-RECEIVE or mid-HOLD SHALL abort the frame with no partial word delivered.
REQ-024 After rst returns to 1, the first active edge SHALL act as an IDLE cycle.

Configuration
REQ-025 Macro TRANSFER_CENTER_PARITY_EN defined: the frame is DATA_WIDTH data bits followed by one even-parity bit, giving an even count of ones over all DATA_WIDTH+1 bits.
REQ-026 With the macro defined and a good frame, the word SHALL be delivered as in REQ-014 to REQ-019.
REQ-027 With the macro defined and a parity error, the FSM SHALL go directly to IDLE, leave dataBuffer unchanged, keep readyForTransferOut at 0, and not toggle the destination pointer.
REQ-028 Macro undefined: the frame is DATA_WIDTH bits, there is no parity logic, and ports are identical in both builds.

Verification
REQ-029 Hold rst=0 for 2 cycles, then release -> dataBuffer=8'h00, readyForTransferOut=0, localScannerOut=00.
REQ-030 readyForTransferIn pulse, then serial 1,0,1,0,0,1,0,1 -> dataBuffer=8'hA5 one cycle after the last bit, readyForTransferOut=1 and localScannerOut=01 for exactly 4 cycles, then 0/00.
REQ-031 Second frame 8'hFF -> dataBuffer=8'hFF, localScannerOut=10; third frame -> 01 again.
REQ-032 rst=0 after bit 5 of a frame -> all outputs cleared at once; next full frame 8'h3C goes to scanner 0.
REQ-033 readyForTransferIn toggled during RECEIVE -> no effect; exactly one word delivered.
REQ-034 TRANSFER_CENTER_PARITY_EN build: 8'hA5 with parity bit 0 -> delivered; 8'hA5 with parity bit 1 -> no delivery, dataBuffer holds its old value, and the pointer is unchanged.
